conv_accum_quant: RTL and testbench

CONV_ACCUM_QUANT -- requirements
Module: conv_accum_quant

---
 rtl/conv_accum_quant.sv | 95 +++++++++
 tb/tb_conv_accum_quant.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/conv_accum_quant.sv
// conv_accum_quant: accumulates adder-tree partial sums per output pixel, adds bias, requantizes to OUT_W
module conv_accum_quant #(
  parameter int IN_W  = 20,
  parameter int ACC_W = 32,
  parameter int OUT_W = 8,
  parameter int SHIFT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    in_last,
  input  logic signed [ACC_W-1:0] bias,
  input  logic                    relu_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat,
  output logic [15:0]             out_cnt,
  output logic                    acc_ovf
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (SHIFT-1);
  localparam logic signed [ACC_W:0] OMAX = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] OMIN = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};
  logic [0:0] state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, base, sum_sat;
  logic signed [ACC_W:0] sum_w, rnd_w, shr;
  logic [15:0] cnt_q, cnt_d, cnt_nxt;
  logic ovf, beat, neg_zero, clip_hi, clip_lo;
  logic signed [OUT_W-1:0] q, out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, out_sat_q, out_sat_d, acc_ovf_q, acc_ovf_d;
  logic [15:0] out_cnt_q, out_cnt_d;
  assign in_ready  = !out_valid_q || out_ready;
  assign beat      = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_cnt   = out_cnt_q;
  assign acc_ovf   = acc_ovf_q;
  // saturating accumulate: a group's first beat starts from bias instead of the running sum
  always_comb begin
    base    = (state_q == IDLE) ? bias : acc_q;
    sum_w   = {base[ACC_W-1], base} + {{(ACC_W+1-IN_W){in_data[IN_W-1]}}, in_data};
    ovf     = sum_w[ACC_W] != sum_w[ACC_W-1];
    sum_sat = ovf ? (sum_w[ACC_W] ? ACC_MIN : ACC_MAX) : sum_w[ACC_W-1:0];
    cnt_nxt = (state_q == IDLE) ? 16'd1 : (&cnt_q ? cnt_q : cnt_q + 16'd1);
  end
  // round half up, arithmetic shift, optional ReLU, then clip to the output range
  always_comb begin
    rnd_w    = {sum_sat[ACC_W-1], sum_sat} + HALF;
    shr      = rnd_w >>> SHIFT;
    neg_zero = relu_en && shr[ACC_W];
    clip_hi  = shr > OMAX;
    clip_lo  = !neg_zero && (shr < OMIN);
    q        = neg_zero ? '0 : clip_hi ? OMAX[OUT_W-1:0] : clip_lo ? OMIN[OUT_W-1:0] : shr[OUT_W-1:0];
  end
  // next state: a last beat loads a fresh result even while the old one is being handed off
  always_comb begin
    state_d     = beat ? (in_last ? IDLE : ACCUM) : state_q;
    acc_d       = beat ? sum_sat : acc_q;
    cnt_d       = beat ? cnt_nxt : cnt_q;
    acc_ovf_d   = acc_ovf_q || (beat && ovf);
    out_valid_d = (beat && in_last) ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    out_data_d  = (beat && in_last) ? q : out_data_q;
    out_sat_d   = (beat && in_last) ? (clip_hi || clip_lo) : out_sat_q;
    out_cnt_d   = (beat && in_last) ? cnt_nxt : out_cnt_q;
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      acc_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      acc_ovf_q   <= acc_ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_cnt_q   <= out_cnt_d;
    end
  end
endmodule

// File: tb/tb_conv_accum_quant.sv
// tb_conv_accum_quant: scoreboard bench with a longint reference model and randomized groups
module tb_conv_accum_quant;
  localparam int IN_W = 20, ACC_W = 32, OUT_W = 8, SHIFT = 8;
  localparam longint A_MAX = (longint'(1) <<< (ACC_W-1)) - 1;
  localparam longint A_MIN = -(longint'(1) <<< (ACC_W-1));
  localparam longint O_MAX = (longint'(1) <<< (OUT_W-1)) - 1;
  localparam longint O_MIN = -(longint'(1) <<< (OUT_W-1));
  typedef struct { longint data; longint sat; longint cnt; } exp_t;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, relu_en = 0, out_ready = 1;
  logic signed [IN_W-1:0] in_data = '0;
  logic signed [ACC_W-1:0] bias = '0;
  logic in_ready, out_valid, out_sat, acc_ovf;
  logic signed [OUT_W-1:0] out_data;
  logic [15:0] out_cnt;
  int n_checks = 0, n_fail = 0;
  bit rnd_rdy = 0;
  exp_t sb[$];
  longint m_acc = 0, m_len = 0;
  bit m_first = 1, m_ovf = 0;
  conv_accum_quant #(.IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .bias(bias), .relu_en(relu_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat), .out_cnt(out_cnt),
    .acc_ovf(acc_ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // reference: each accepted beat adds to the pixel sum, clamped to the accumulator range
  task automatic model_beat(input longint d, input longint b, input bit last, input bit relu);
    longint s, r;
    exp_t e;
    s = (m_first ? b : m_acc) + d;
    if (s > A_MAX) begin s = A_MAX; m_ovf = 1; end
    else if (s < A_MIN) begin s = A_MIN; m_ovf = 1; end
    m_acc = s;
    m_len = m_first ? 1 : m_len + 1;
    m_first = last;
    if (last) begin
      r = (s + (longint'(1) <<< (SHIFT-1))) >>> SHIFT;
      e.sat = 0;
      if (relu && r < 0) r = 0;
      else if (r > O_MAX) begin r = O_MAX; e.sat = 1; end
      else if (r < O_MIN) begin r = O_MIN; e.sat = 1; end
      e.data = r;
      e.cnt = (m_len > 65535) ? 65535 : m_len;
      sb.push_back(e);
    end
  endtask
  // offer one beat; the model is updated at the negedge where in_ready shows it will be taken
  task automatic send(input longint d, input bit last, input longint b, input bit relu);
    int n = 0;
    in_valid = 1; in_data = d[IN_W-1:0]; in_last = last; bias = b[ACC_W-1:0]; relu_en = relu;
    @(negedge clk);
    while (!in_ready && n < 200) begin n++; @(negedge clk); end
    if (!in_ready) chk("send_timeout", 0, 1);
    else model_beat(d, b, last, relu);
    @(posedge clk); #1;
    in_valid = 0; in_data = IN_W'($urandom); in_last = 1'($urandom); bias = ACC_W'($urandom); relu_en = 1'($urandom);
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 1000) begin @(posedge clk); n++; end
    chk("drain_left", sb.size(), 0);
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    m_first = 1; m_ovf = 0; m_acc = 0; m_len = 0;
    sb.delete();
  endtask
  // monitor: every accepted result must match the oldest expected one
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        e = sb.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_sat", out_sat, e.sat);
        chk("out_cnt", out_cnt, e.cnt);
      end
    end
  end
  // random backpressure when enabled
  initial forever begin
    @(posedge clk); #1;
    if (rnd_rdy) out_ready = 1'($urandom);
  end
  initial begin
    logic signed [OUT_W-1:0] d0;
    longint b;
    int len;
    @(posedge clk); #1;
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_acc_ovf", acc_ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    send(256, 0, 128, 0);
    send(512, 0, 0, 0);
    chk("mid_group_out_valid", out_valid, 0);
    send(-128, 1, 0, 0);
    chk("latency_out_valid", out_valid, 1);
    chk("basic_data", out_data, 3);
    chk("basic_cnt", out_cnt, 3);
    drain();
    send(100000, 1, 0, 0);
    chk("pos_clip", out_data, 127);
    send(-100000, 1, 0, 0);
    chk("neg_clip", out_data, -128);
    send(-100000, 1, 0, 1);
    chk("relu_zero", out_data, 0);
    chk("relu_sat", out_sat, 0);
    drain();
    out_ready = 0;
    send(50000, 1, 0, 0);
    d0 = out_data;
    in_valid = 1; in_data = -20'sd300; in_last = 1; bias = '0; relu_en = 0;
    repeat (4) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_data_stable", out_data, d0);
      chk("stall_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    out_ready = 1;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    model_beat(-300, 0, 1, 0);
    @(posedge clk); #1;
    in_valid = 0;
    chk("no_bubble_valid", out_valid, 1);
    chk("replaced_data", out_data, -1);
    drain();
    send(100, 0, 0, 0);
    send(200, 0, 0, 0);
    do_reset();
    send(512, 1, 0, 0);
    chk("after_rst_data", out_data, 2);
    chk("after_rst_cnt", out_cnt, 1);
    drain();
    rnd_rdy = 1;
    for (int g = 0; g < 60; g++) begin
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        b = $urandom_range(0, 1) ? (longint'(int'($urandom)) >>> 2) : longint'($urandom_range(0, 2000)) - 1000;
        send(longint'($urandom_range(0, 1048575)) - 524288, k == len - 1, b, 1'($urandom));
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      end
      chk("rand_acc_ovf", acc_ovf, m_ovf);
    end
    rnd_rdy = 0;
    @(posedge clk); #1;
    out_ready = 1;
    drain();
    send(100, 0, 64'h7FFFFFF0, 0);
    chk("ovf_set", acc_ovf, 1);
    send(0, 1, 0, 0);
    chk("ovf_data", out_data, 127);
    chk("ovf_sat", out_sat, 1);
    send(512, 1, 0, 0);
    chk("ovf_sticky", acc_ovf, 1);
    chk("ovf_model", acc_ovf, m_ovf);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
